// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with start/busy/done handshake and synchronous flush.
module rv_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int PW = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic            neg_q, neg_d;
  logic            spec_q, spec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] spec_val;
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_next;
  logic [XLEN:0]   div_rem;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;
  logic [PW-1:0]   div_next;
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] quo, rem, quo_s, rem_s;
  logic [XLEN-1:0] fin;

  // Operand decode at acceptance: magnitudes, negate flag and the two bypass cases.
  always_comb begin
    accept   = start && !flush && !busy_q && (state_q != CALC);
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sign_a   = a_signed && rs1[XLEN-1];
    sign_b   = b_signed && rs2[XLEN-1];
    mag_a    = sign_a ? (~rs1 + XLEN'(1)) : rs1;
    mag_b    = sign_b ? (~rs2 + XLEN'(1)) : rs2;
    div_zero = op[2] && (rs2 == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == INT_MIN) && (rs2 == '1);
    if (div_zero) begin
      spec_val = op[1] ? rs1 : '1;
    end else begin
      spec_val = op[1] ? '0 : INT_MIN;
    end
  end

  // One iteration step for each datapath; acc holds {hi,lo} or {remainder,quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_rem  = acc_q[PW-1:XLEN-1];
    div_ge   = div_rem >= {1'b0, b_q};
    div_diff = div_rem[XLEN-1:0] - b_q;
    div_next = {div_ge ? div_diff : div_rem[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
  end

  always_comb begin
    prod  = neg_q ? (~acc_q + PW'(1)) : acc_q;
    quo   = acc_q[XLEN-1:0];
    rem   = acc_q[PW-1:XLEN];
    quo_s = neg_q ? (~quo + XLEN'(1)) : quo;
    rem_s = neg_q ? (~rem + XLEN'(1)) : rem;
    if (spec_q) begin
      fin = acc_q[XLEN-1:0];
    end else if (op_q[2]) begin
      fin = op_q[1] ? rem_s : quo_s;
    end else if (op_q == OP_MUL) begin
      fin = prod[XLEN-1:0];
    end else begin
      fin = prod[PW-1:XLEN];
    end
  end

  // Next-state logic; busy/done are registered from the current state, so they trail it by one edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    busy_d   = (state_q == CALC);
    done_d   = (state_q == DONE);
    result_d = (state_q == DONE) ? fin : result_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          op_d   = op;
          a_d    = mag_a;
          b_d    = mag_b;
          cnt_d  = '0;
          neg_d  = (op == OP_REM) ? sign_a : (sign_a ^ sign_b);
          spec_d = div_zero || div_ovf;
          if (div_zero || div_ovf) begin
            acc_d   = {{XLEN{1'b0}}, spec_val};
            state_d = DONE;
          end else begin
            acc_d   = op[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        if (cnt_q == '1) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Directed testbench for rv_muldiv: hand-computed RV32M results, latencies,
// flush, back-to-back issue, ignored start during CALC and asynchronous reset.
module tb_rv_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  rv_muldiv #(.XLEN(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; presents one start pulse across the next rising edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles counted from the acceptance edge; returns at the negedge where done is seen.
  task automatic waitDone(output int cycles, output int busyCycles);
    cycles     = 0;
    busyCycles = busy ? 1 : 0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (busy) busyCycles++;
    end
  endtask

  task automatic watchNoDone(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) seen++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected, input int expLat);
    int lat;
    int bc;
    applyStimulus(o, a, b);
    waitDone(lat, bc);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_res"}, result, expected);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int bc;
    int seen;
    logic [31:0] held;

    $display("[TB] rv_muldiv directed test start");
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'b000;
    rs1   = '0;
    rs2   = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD);
    waitDone(lat, bc);
    checkOutput("mul_lat", 32'(lat), 32'd33);
    checkOutput("mul_busy_cycles", 32'(bc), 32'd32);
    checkOutput("mul_res", result, 32'hFFFF_FFEB);
    @(negedge clk);
    checkOutput("mul_done_pulse", 32'(done), 32'd0);

    runOp("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    runOp("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    runOp("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    runOp("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    runOp("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    runOp("divu",   3'b101, 32'd100,       32'd7,         32'd14,        33);
    runOp("remu",   3'b111, 32'd100,       32'd7,         32'd2,         33);
    runOp("divu_z", 3'b101, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1);
    runOp("rem_z",  3'b110, 32'h1234,      32'd0,         32'h1234,      1);
    runOp("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    runOp("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    held = result;
    applyStimulus(3'b100, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_result", result, held);
    watchNoDone(40, seen);
    checkOutput("flush_no_done", 32'(seen), 32'd0);
    checkOutput("flush_result_late", result, held);

    op    = 3'b000;
    rs1   = 32'd3;
    rs2   = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flush_start_busy", 32'(busy), 32'd0);
    watchNoDone(40, seen);
    checkOutput("flush_start_no_done", 32'(seen), 32'd0);

    runOp("mul_3x5", 3'b000, 32'd3, 32'd5, 32'd15, 33);

    applyStimulus(3'b000, 32'd6, 32'd7);
    waitDone(lat, bc);
    checkOutput("b2b_first_res", result, 32'd42);
    applyStimulus(3'b101, 32'd1000, 32'd10);
    checkOutput("b2b_result_stable", result, 32'd42);
    waitDone(lat, bc);
    checkOutput("b2b_second_lat", 32'(lat), 32'd33);
    checkOutput("b2b_second_res", result, 32'd100);
    @(negedge clk);

    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'd2);
    repeat (4) @(negedge clk);
    op    = 3'b101;
    rs1   = 32'h1234;
    rs2   = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("calc_start_busy", 32'(busy), 32'd1);
    waitDone(lat, bc);
    checkOutput("calc_start_lat", 32'(lat), 32'd28);
    checkOutput("calc_start_res", result, 32'd1);
    watchNoDone(5, seen);
    checkOutput("calc_start_no_extra", 32'(seen), 32'd0);

    applyStimulus(3'b000, 32'd9, 32'd9);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_done", 32'(done), 32'd0);
    checkOutput("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watchNoDone(40, seen);
    checkOutput("rst_mid_no_done", 32'(seen), 32'd0);
    checkOutput("rst_mid_result_late", result, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
